dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port 256x8 data memory between the CPU datapath and an I/O/DMA requester. It grants at most one access per clock, drives the memory port, and returns registered read data with a one-cycle valid strobe. It sits between the load/store path and the data memory instance, and replaces the direct CPU-to-memory wiring.

## Interface
Parameters:
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width
- MAX_WAIT, 3, consecutive denied I/O cycles before the I/O requester is promoted (1..7)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req / io_req  in  1  access request; held until granted
- cpu_we / io_we  in  1  1 = write, 0 = read; stable while req is high
- cpu_addr / io_addr  in  AW  address; stable while req is high
- cpu_wd / io_wd  in  DW  write data; stable while req is high
- cpu_gnt / io_gnt  out  1  combinational grant; the access occurs in the cycle where req & gnt
- cpu_rd / io_rd  out  DW  registered read data
- cpu_rvalid / io_rvalid  out  1  one-cycle pulse, the cycle after a granted read
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory combinational read data

## Operation
- The wait counter wcnt (3 bits) counts consecutive cycles with io_req=1 and io_gnt=0.
- Default priority goes to the CPU: cpu_gnt = cpu_req & ~promote; io_gnt = io_req & (~cpu_req | promote).
- promote = (wcnt >= MAX_WAIT).
- Counter update:
  - wcnt <= 0 on an I/O grant or when io_req=0.
  - wcnt increments on a denied I/O request and saturates at 7.
- Memory port:
  - The granted requester's addr/wd drive mem_addr/mem_wd.
  - mem_we = granted requester's we.
  - With no grant: mem_we=0 and mem_addr/mem_wd hold the CPU inputs (don't-care, but deterministic).
- A write commits at the clock edge that ends the granted cycle.
- A read captures mem_rd into xx_rd at that edge, and xx_rd holds until the next granted read by the same requester.
- Simultaneous requests resolve to exactly one grant. The loser keeps req high and is served later with no lost transaction.
- Back-to-back grants to the same requester are legal, one per cycle.
- While reset is high, all gnt outputs and mem_we are forced to 0, so no write can commit.

## Timing
- Reset values:
  - cpu_rd, io_rd = 0
  - cpu_rvalid, io_rvalid = 0
  - wcnt = 0
  - cpu_gnt, io_gnt, mem_we = 0 (forced while reset is asserted)
- Grant latency is 0 cycles (combinational).
- Read data latency is 1 cycle: rvalid is high in cycle N+1 for a read granted in cycle N.
- A write has no response strobe. The written value is visible to a read granted in the following cycle.
- I/O worst-case wait under continuous CPU requests is MAX_WAIT cycles, then the I/O requester is granted on the next cycle.
- Reset asserted mid-access: a granted cycle aborted by reset does not commit, and a pending rvalid is cleared immediately.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Priority alternates.
  - A 1-bit last-grant register (reset 0 = CPU last) gives a contended cycle to the requester not granted last.
  - wcnt and MAX_WAIT are unused.
- Undefined: CPU-priority with MAX_WAIT starvation promotion, as described above.

## Structure
- The shared package holds:
  - Requester index constants: REQ_CPU=0, REQ_IO=1.
  - Default widths AW=8 and DW=8, shared with the data memory and the register file.
- One sub-module, dmem_arb_pick: the pure grant logic (req pair, promote/last-grant in, one-hot grant out).
- Read-data registers, counters and muxing stay in the top module.

## Test plan
- CPU-only: write 0xA5 at 0x10 in cycle 0, read 0x10 in cycle 1 -> cpu_gnt=1 both cycles, cpu_rvalid=1 in cycle 2, cpu_rd=0xA5.
- Contention, default build, MAX_WAIT=3: both requesters continuously reading 0x01 -> cpu granted cycles 0-2, io granted cycle 3, wcnt returns to 0, and the pattern repeats.
- I/O writes 0x3C at 0x20, CPU reads 0x20 in the following cycle -> cpu_rd=0x3C; io_rvalid stays 0 because the I/O access was a write.
- Reset asserted for one cycle during a granted CPU write of 0xFF at 0x05 -> mem_we=0, the location keeps its old value, and all rd/rvalid outputs read 0.
- DMEM_ARB_RR_EN build: both requesters continuously requesting -> grants alternate io, cpu, io, cpu starting with io after reset.
- Idle: no requests -> mem_we=0, both rvalid outputs 0, and rd values hold their last captured data.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: requester indices, default widths,
// and a saturating helper for the I/O wait counter.
package dmem_arbiter_pkg;

  localparam int REQ_CPU = 0;
  localparam int REQ_IO  = 1;
  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 8;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd7) begin
      r = 3'd7;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Pure grant logic: one-hot grant from the request pair. prio_io_i decides
// who wins only when both requesters ask in the same cycle.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_io_i,
  output logic [1:0] gnt_o
);

  // Contention goes to the prioritised requester; otherwise the lone requester wins.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[REQ_CPU] && req_i[REQ_IO]) begin
      if (prio_io_i) begin
        gnt_o[REQ_IO] = 1'b1;
      end else begin
        gnt_o[REQ_CPU] = 1'b1;
      end
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Define DMEM_ARB_RR_EN
// for alternating priority; otherwise CPU priority with MAX_WAIT I/O promotion.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wd,
  output logic          cpu_gnt,
  output logic          io_gnt,
  output logic [DW-1:0] cpu_rd,
  output logic [DW-1:0] io_rd,
  output logic          cpu_rvalid,
  output logic          io_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic [1:0]    req_s;
  logic [1:0]    pick_s;
  logic          prio_io_s;
  logic          cpu_gnt_s;
  logic          io_gnt_s;
  logic          cpu_rvalid_d, cpu_rvalid_q;
  logic          io_rvalid_d, io_rvalid_q;
  logic [DW-1:0] cpu_rd_d, cpu_rd_q;
  logic [DW-1:0] io_rd_d, io_rd_q;

  always_comb begin
    req_s          = 2'b00;
    req_s[REQ_CPU] = cpu_req;
    req_s[REQ_IO]  = io_req;
  end

`ifdef DMEM_ARB_RR_EN
  logic last_io_d, last_io_q;

  assign prio_io_s = ~last_io_q;

  always_comb begin
    if (cpu_gnt_s) begin
      last_io_d = 1'b0;
    end else if (io_gnt_s) begin
      last_io_d = 1'b1;
    end else begin
      last_io_d = last_io_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_io_q <= 1'b0;
    end else begin
      last_io_q <= last_io_d;
    end
  end
`else
  logic [2:0] wcnt_d, wcnt_q;

  assign prio_io_s = (wcnt_q >= 3'(MAX_WAIT));

  always_comb begin
    if (!io_req || io_gnt_s) begin
      wcnt_d = 3'd0;
    end else begin
      wcnt_d = sat_inc3(wcnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= 3'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  dmem_arb_pick u_pick (
    .req_i     (req_s),
    .prio_io_i (prio_io_s),
    .gnt_o     (pick_s)
  );

  // Grants are masked during reset so an aborted cycle can never write.
  assign cpu_gnt_s = pick_s[REQ_CPU] & ~reset;
  assign io_gnt_s  = pick_s[REQ_IO] & ~reset;

  always_comb begin
    mem_addr = cpu_addr;
    mem_wd   = cpu_wd;
    mem_we   = 1'b0;
    if (io_gnt_s) begin
      mem_addr = io_addr;
      mem_wd   = io_wd;
      mem_we   = io_we;
    end else if (cpu_gnt_s) begin
      mem_we = cpu_we;
    end else begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    cpu_rvalid_d = cpu_gnt_s & ~cpu_we;
    io_rvalid_d  = io_gnt_s & ~io_we;
    cpu_rd_d     = cpu_rvalid_d ? mem_rd : cpu_rd_q;
    io_rd_d      = io_rvalid_d ? mem_rd : io_rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      io_rvalid_q  <= 1'b0;
      cpu_rd_q     <= '0;
      io_rd_q      <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      io_rvalid_q  <= io_rvalid_d;
      cpu_rd_q     <= cpu_rd_d;
      io_rd_q      <= io_rd_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign io_gnt     = io_gnt_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign io_rvalid  = io_rvalid_q;
  assign cpu_rd     = cpu_rd_q;
  assign io_rd      = io_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 memory behind the port.
// Memory preload: mem[a] = a ^ 8'hC3.
module tb_dmem_arbiter;

  localparam int MW = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, io_req, io_we;
  logic [7:0] cpu_addr, cpu_wd, io_addr, io_wd;
  logic       cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_we;
  logic [7:0] cpu_rd, io_rd, mem_addr, mem_wd, mem_rd;
  logic       init_mem;
  logic [7:0] mem_m [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       cr, cw;
    logic [7:0] ca, cd;
    logic       ir, iw;
    logic [7:0] ia, id;
    logic       e_cg, e_ig, e_we;
    logic [7:0] e_ma, e_md;
    logic       e_crv;
    logic [7:0] e_crd;
    logic       e_irv;
    logic [7:0] e_ird;
  } vec_t;

  vec_t vecs [8];

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wd(io_wd),
    .cpu_gnt(cpu_gnt), .io_gnt(io_gnt), .cpu_rd(cpu_rd), .io_rd(io_rd),
    .cpu_rvalid(cpu_rvalid), .io_rvalid(io_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem_m[mem_addr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= 8'(i) ^ 8'hC3;
    end else if (mem_we) begin
      mem_m[mem_addr] <= mem_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
    input logic ir, input logic iw, input logic [7:0] ia, input logic [7:0] id,
    input logic e_cg, input logic e_ig, input logic e_we, input logic [7:0] e_ma,
    input logic [7:0] e_md, input logic e_crv, input logic [7:0] e_crd,
    input logic e_irv, input logic [7:0] e_ird);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.ir = ir; v.iw = iw; v.ia = ia; v.id = id;
    v.e_cg = e_cg; v.e_ig = e_ig; v.e_we = e_we; v.e_ma = e_ma; v.e_md = e_md;
    v.e_crv = e_crv; v.e_crd = e_crd; v.e_irv = e_irv; v.e_ird = e_ird;
    return v;
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic ir, input logic iw, input logic [7:0] ia, input logic [7:0] id);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
    io_req = ir; io_we = iw; io_addr = ia; io_wd = id;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic exp_io, exp_cpu;

    reset = 1'b1;
    init_mem = 1'b1;
    drive(1'b1, 1'b1, 8'h05, 8'hFF, 1'b1, 1'b1, 8'h06, 8'hEE);
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(posedge clk); #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_io_gnt", 32'(io_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalids", 32'({cpu_rvalid, io_rvalid}), 32'd0);
    chk("rst_rds", 32'({cpu_rd, io_rd}), 32'd0);
    chk("rst_no_commit", 32'(mem_m[5]), 32'hC6);
    idle();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    //            cr   cw   ca     cd     ir   iw   ia     id     cg   ig   we   ma     md     crv  crd    irv  ird
    vecs[0] = mk(1'b0,1'b0,8'h00,8'h11, 1'b0,1'b0,8'h44,8'h22, 1'b0,1'b0,1'b0,8'h00,8'h11, 1'b0,8'h00, 1'b0,8'h00);
    vecs[1] = mk(1'b1,1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h44,8'h22, 1'b1,1'b0,1'b1,8'h10,8'hA5, 1'b0,8'h00, 1'b0,8'h00);
    vecs[2] = mk(1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h44,8'h22, 1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,8'hA5, 1'b0,8'h00);
    vecs[3] = mk(1'b0,1'b0,8'h33,8'h77, 1'b0,1'b0,8'h44,8'h22, 1'b0,1'b0,1'b0,8'h33,8'h77, 1'b0,8'hA5, 1'b0,8'h00);
    vecs[4] = mk(1'b0,1'b0,8'h33,8'h77, 1'b1,1'b1,8'h20,8'h3C, 1'b0,1'b1,1'b1,8'h20,8'h3C, 1'b0,8'hA5, 1'b0,8'h00);
    vecs[5] = mk(1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h44,8'h22, 1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,8'h3C, 1'b0,8'h00);
    vecs[6] = mk(1'b0,1'b0,8'h20,8'h00, 1'b1,1'b0,8'h05,8'h99, 1'b0,1'b1,1'b0,8'h05,8'h99, 1'b0,8'h3C, 1'b1,8'hC6);
    vecs[7] = mk(1'b0,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h05,8'h99, 1'b0,1'b0,1'b0,8'h20,8'h00, 1'b0,8'h3C, 1'b0,8'hC6);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].ir, vecs[i].iw, vecs[i].ia, vecs[i].id);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_cg));
      chk($sformatf("v%0d_io_gnt", i), 32'(io_gnt), 32'(vecs[i].e_ig));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
      chk($sformatf("v%0d_mem_wd", i), 32'(mem_wd), 32'(vecs[i].e_md));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
      chk($sformatf("v%0d_cpu_rd", i), 32'(cpu_rd), 32'(vecs[i].e_crd));
      chk($sformatf("v%0d_io_rvalid", i), 32'(io_rvalid), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_io_rd", i), 32'(io_rd), 32'(vecs[i].e_ird));
    end

    // Continuous contention, both reading 0x01 (preload 0xC2), from a fresh reset.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00);
`ifdef DMEM_ARB_RR_EN
      exp_io = ((k % 2) == 0);
`else
      exp_io = ((k % (MW + 1)) == MW);
`endif
      exp_cpu = ~exp_io;
      @(negedge clk);
      chk($sformatf("c%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(exp_cpu));
      chk($sformatf("c%0d_io_gnt", k), 32'(io_gnt), 32'(exp_io));
      @(posedge clk); #1;
      chk($sformatf("c%0d_cpu_rvalid", k), 32'(cpu_rvalid), 32'(exp_cpu));
      chk($sformatf("c%0d_io_rvalid", k), 32'(io_rvalid), 32'(exp_io));
      if (exp_cpu) chk($sformatf("c%0d_cpu_rd", k), 32'(cpu_rd), 32'hC2);
      else         chk($sformatf("c%0d_io_rd", k), 32'(io_rd), 32'hC2);
    end

    // Reset during a granted CPU write of 0xFF to 0x05.
    drive(1'b1, 1'b1, 8'h05, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("abort_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("abort_mem5", 32'(mem_m[5]), 32'hC6);
    chk("abort_rds", 32'({cpu_rd, io_rd}), 32'd0);
    chk("abort_rvalids", 32'({cpu_rvalid, io_rvalid}), 32'd0);
    idle();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Pending rvalid cleared as soon as reset asserts.
    drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("pend_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("pend_cpu_rd", 32'(cpu_rd), 32'hC6);
    reset = 1'b1;
    #1;
    chk("pend_rvalid_clr", 32'(cpu_rvalid), 32'd0);
    chk("pend_rd_clr", 32'(cpu_rd), 32'd0);
    idle();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Read 0x10 (0xA5 written earlier), then idle: data holds, no strobes.
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_mem_we", k), 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("idle%0d_rvalids", k), 32'({cpu_rvalid, io_rvalid}), 32'd0);
      chk($sformatf("idle%0d_cpu_rd", k), 32'(cpu_rd), 32'hA5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
